// File: rtl/gbsha_fir_driver.sv
// Sequencer for a 5-tap FIR pin interface: loads coefficients, then streams samples and returns tagged results.
// Latency 4 cycles from sample handshake to m_valid; s_ready only in STREAM, no backpressure on results.
module gbsha_fir_driver #(
    parameter int N_TAPS = 5,
    parameter int BW_in  = 6,
    parameter int BW_out = 8,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [BW_in-1:0]  cfg_data,
    input  logic              start,
    input  logic              stop,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BW_in-1:0]  s_data,
    output logic              fir_reset,
    output logic [BW_in-1:0]  fir_x,
    input  logic [BW_out-1:0] fir_y,
    output logic              m_valid,
    output logic [BW_out-1:0] m_data,
    output logic              busy,
    output logic              underrun
);

    localparam int CNT_MAX = (N_TAPS > LAT) ? N_TAPS : LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [BW_in-1:0]   x_nxt;
    logic               tag_in;
    logic               und_nxt;
    logic               accepted;
    logic               acc_nxt;
    logic [LAT-2:0]     tag_pipe;
    logic [BW_in-1:0]   coef [N_TAPS];
    logic               cfg_wr;

    assign s_ready = (state == STREAM);
    assign cfg_wr  = (state == IDLE) && !start && cfg_we && (int'(cfg_addr) < N_TAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt counts down through the load (coefficient index) and drain phases
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = '0;
        tag_in    = 1'b0;
        und_nxt   = underrun;
        acc_nxt   = accepted;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = CNT_W'(N_TAPS - 1);
                    x_nxt     = coef[N_TAPS-1];
                    und_nxt   = 1'b0;
                    acc_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (cnt == '0) begin
                    state_nxt = STREAM;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    x_nxt   = coef[cnt - CNT_W'(1)];
                end
            end
            STREAM: begin
                if (s_valid) begin
                    x_nxt   = s_data;
                    tag_in  = 1'b1;
                    acc_nxt = 1'b1;
                end else if (accepted) begin
                    und_nxt = 1'b1;
                end
                if (stop) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(LAT - 1);
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tag_pipe mirrors the FIR pipeline so m_valid lines up with the captured fir_y
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            fir_reset <= 1'b1;
            fir_x     <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
            accepted  <= 1'b0;
            tag_pipe  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                coef[k] <= '0;
            end
        end else begin
            cnt       <= cnt_nxt;
            fir_reset <= (state_nxt == IDLE);
            fir_x     <= x_nxt;
            busy      <= (state_nxt != IDLE);
            underrun  <= und_nxt;
            accepted  <= acc_nxt;
            tag_pipe  <= {tag_pipe[LAT-3:0], tag_in};
            m_valid   <= tag_pipe[LAT-2];
            m_data    <= fir_y;
            if (cfg_wr) begin
                coef[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_gbsha_fir_driver.sv
// Bench for gbsha_fir_driver: behavioural FIR on the pins, table vectors, corner sequences and random streams.
module tb_gbsha_fir_driver;

    localparam int MAXC = 8192;
    localparam int GAP  = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       start;
    logic       stop;
    logic       s_valid;
    logic       s_ready;
    logic [5:0] s_data;
    logic       fir_reset;
    logic [5:0] fir_x;
    logic [7:0] fir_y;
    logic       m_valid;
    logic [7:0] m_data;
    logic       busy;
    logic       underrun;

    gbsha_fir_driver dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .stop     (stop),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .fir_reset(fir_reset),
        .fir_x    (fir_x),
        .fir_y    (fir_y),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int sx6(input logic [5:0] v);
        return int'($signed(v));
    endfunction

    // Pin-level FIR: after reset the first 5 inputs shift in as coefficients, then samples.
    int fir_c  [5];
    int fir_xl [5];
    int fir_ld;

    function automatic logic [7:0] fir_sum();
        int a;
        a = 0;
        for (int k = 0; k < 5; k++) a += fir_c[k] * fir_xl[k];
        return a[7:0];
    endfunction

    always @(posedge clk) begin
        if (fir_reset) begin
            fir_ld <= 0;
            fir_y  <= 8'h00;
            for (int k = 0; k < 5; k++) begin
                fir_c[k]  <= 0;
                fir_xl[k] <= 0;
            end
        end else if (fir_ld < 5) begin
            fir_c[0] <= sx6(fir_x);
            for (int k = 1; k < 5; k++) fir_c[k] <= fir_c[k-1];
            fir_ld <= fir_ld + 1;
        end else begin
            fir_xl[0] <= sx6(fir_x);
            for (int k = 1; k < 5; k++) fir_xl[k] <= fir_xl[k-1];
            fir_y <= fir_sum();
        end
    end

    // Reference: y[n] = sum c[k]*x[n-k] over the stream history, low 8 bits.
    int         coef_m [5];
    int         xhist [$];
    int         plan [$];
    logic [7:0] rx_q [$];
    bit         exp_vld [MAXC];
    logic [7:0] exp_dat [MAXC];
    bit         exp_und;
    bit         chk_on = 1'b0;

    function automatic logic [7:0] model_y();
        int a;
        int n;
        a = 0;
        n = xhist.size();
        for (int k = 0; k < 5; k++) begin
            if (n - 1 - k >= 0) a += coef_m[k] * xhist[n-1-k];
        end
        return a[7:0];
    endfunction

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            check("m_valid", int'(m_valid), int'(exp_vld[cyc]));
            if (exp_vld[cyc]) check("m_data", int'(m_data), int'(exp_dat[cyc]));
            if (m_valid) rx_q.push_back(m_data);
        end
    end

    typedef struct packed {
        logic [3:0]       n;
        logic [4:0][5:0]  c;   // listed c0 first: coefficient k is c[4-k]
        logic [7:0][5:0]  x;   // sample j is x[7-j]
        logic [7:0][7:0]  y;   // result j is y[7-j]
    } vec_t;

    vec_t tbl [6];

    task automatic program_coefs(input logic [4:0][5:0] c);
        for (int k = 0; k < 5; k++) begin
            cfg_we    = 1'b1;
            cfg_addr  = 3'(k);
            cfg_data  = c[4-k];
            coef_m[k] = sx6(c[4-k]);
            @(posedge clk); #1;
        end
        cfg_we   = 1'b1;
        cfg_addr = 3'd5;
        cfg_data = 6'h2A;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Called one time unit after a rising edge while the DUT is in IDLE.
    task automatic run_session(input bit inject);
        int  last;
        bit  acc;
        xhist.delete();
        rx_q.delete();
        exp_und = 1'b0;
        acc     = 1'b0;
        last    = plan.size() - 1;
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 6'h15;
        @(posedge clk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        check("busy_load", int'(busy), 1);
        check("fir_reset_load", int'(fir_reset), 0);
        check("underrun_clr", int'(underrun), 0);
        check("s_ready_load", int'(s_ready), 0);
        check("fir_x_c4", int'(fir_x), coef_m[4] & 63);
        repeat (4) begin @(posedge clk); #1; end
        check("s_ready_load_end", int'(s_ready), 0);
        check("fir_x_c0", int'(fir_x), coef_m[0] & 63);
        @(posedge clk); #1;
        check("fir_x_bubble", int'(fir_x), 0);
        for (int j = 0; j <= last; j++) begin
            check("s_ready_stream", int'(s_ready), 1);
            if (plan[j] == GAP) begin
                s_valid = 1'b0;
                xhist.push_back(0);
                if (acc) exp_und = 1'b1;
            end else begin
                s_valid = 1'b1;
                s_data  = 6'(plan[j]);
                xhist.push_back(plan[j]);
                acc = 1'b1;
            end
            stop = (j == last);
            if (inject && j == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd0;
                cfg_data = 6'h07;
                start    = 1'b1;
            end
            if (cyc + 4 < MAXC) begin
                exp_vld[cyc+4] = (plan[j] != GAP);
                exp_dat[cyc+4] = model_y();
            end
            @(posedge clk); #1;
            s_valid = 1'b0;
            stop    = 1'b0;
            cfg_we  = 1'b0;
            start   = 1'b0;
        end
        check("busy_drain", int'(busy), 1);
        check("underrun", int'(underrun), int'(exp_und));
        repeat (3) begin @(posedge clk); #1; end
        check("busy_drain_end", int'(busy), 1);
        check("fir_reset_drain_end", int'(fir_reset), 0);
        @(posedge clk); #1;
        check("busy_idle", int'(busy), 0);
        check("fir_reset_idle", int'(fir_reset), 1);
        check("s_ready_idle", int'(s_ready), 0);
        check("underrun_sticky", int'(underrun), int'(exp_und));
    endtask

    task automatic check_rx(input vec_t v);
        check("rx_count", rx_q.size(), int'(v.n));
        for (int j = 0; j < int'(v.n) && j < rx_q.size(); j++) begin
            check("rx_data", int'(rx_q[j]), int'(v.y[7-j]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [4:0][5:0] rc;
        int n;
        tbl[0] = '{n: 4'd3, c: {6'd1, 6'd0, 6'd0, 6'd0, 6'd0},
                   x: {6'd5, 6'h3D, 6'd31, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
                   y: {8'h05, 8'hFD, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[1] = '{n: 4'd4, c: {6'd0, 6'd0, 6'd1, 6'd0, 6'd0},
                   x: {6'd7, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
                   y: {8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[2] = '{n: 4'd1, c: {6'h20, 6'd0, 6'd0, 6'd0, 6'd0},
                   x: {6'd31, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
                   y: {8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[3] = '{n: 4'd5, c: {6'h20, 6'h20, 6'h20, 6'h20, 6'h20},
                   x: {6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'd0, 6'd0, 6'd0},
                   y: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        tbl[4] = '{n: 4'd6, c: {6'd1, 6'd2, 6'd3, 6'd4, 6'd5},
                   x: {6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd0, 6'd0},
                   y: {8'h01, 8'h03, 8'h06, 8'h0A, 8'h0F, 8'h0F, 8'h00, 8'h00}};
        tbl[5] = '{n: 4'd3, c: {6'd2, 6'h3F, 6'd0, 6'd0, 6'd0},
                   x: {6'd10, 6'd20, 6'h3B, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
                   y: {8'h14, 8'h1E, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 6'd0;
        start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fir_reset", int'(fir_reset), 1);
        check("rst_fir_x", int'(fir_x), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_underrun", int'(underrun), 0);
        reset  = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            program_coefs(tbl[i].c);
            plan.delete();
            for (int j = 0; j < int'(tbl[i].n); j++) plan.push_back(sx6(tbl[i].x[7-j]));
            run_session(1'b0);
            check_rx(tbl[i]);
        end

        // one-cycle gap mid-stream: one missing m_valid, underrun set, cleared by next start
        program_coefs(tbl[0].c);
        plan = '{3, GAP, 4, 9};
        run_session(1'b0);
        check("underrun_gap_rx", rx_q.size(), 3);
        plan = '{5, -3, 31, 2, 6};
        run_session(1'b1);
        check("ignored_ctrl_rx", rx_q.size(), 5);

        // reset during the third load cycle
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midload_fir_reset", int'(fir_reset), 1);
        check("midload_busy", int'(busy), 0);
        check("midload_s_ready", int'(s_ready), 0);
        check("midload_fir_x", int'(fir_x), 0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) coef_m[k] = 0;
        @(posedge clk); #1;
        plan = '{9, 9};
        run_session(1'b0);
        program_coefs(tbl[0].c);
        plan.delete();
        for (int j = 0; j < int'(tbl[0].n); j++) plan.push_back(sx6(tbl[0].x[7-j]));
        run_session(1'b0);
        check_rx(tbl[0]);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 5; k++) rc[k] = 6'($urandom_range(0, 63));
            program_coefs(rc);
            plan.delete();
            n = int'($urandom_range(12, 30));
            for (int j = 0; j < n; j++) begin
                if (j > 0 && j < n - 1 && $urandom_range(0, 99) < 20) plan.push_back(GAP);
                else plan.push_back(int'($urandom_range(0, 63)) - 32);
            end
            run_session(r[0]);
        end

        repeat (6) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gbsha_fir_driver.md
# gbsha_fir_driver

Host-side sequencer for the 5-tap FIR pin interface. It holds the coefficient set and drives the FIR's reset and 6-bit sample bus through the coefficient-load phase and then the streaming phase. It captures the FIR's 8-bit output and returns each result to the host, tagged so it lines up with the sample that produced it. It shares the FIR's clock and sits between the host stream and the FIR pins: io_in[0]=clk, io_in[1]=fir_reset, io_in[7:2]=fir_x, and fir_y=io_out.

## Interface
- N_TAPS, 5, number of taps; must match the FIR
- BW_in, 6, coefficient and sample width, two's complement
- BW_out, 8, FIR output width
- LAT, 4, cycles from sample handshake to m_valid; fixed by the FIR pipeline

Ports:
- clk  in  1  single clock, shared with the FIR
- reset  in  1  synchronous, active-high
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  3  coefficient index k; writes with k >= N_TAPS are ignored
- cfg_data  in  BW_in  coefficient c[k]
- start  in  1  begins load+stream; one-cycle pulse
- stop  in  1  ends streaming; one-cycle pulse
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream sample ready
- s_data  in  BW_in  upstream sample
- fir_reset  out  1  to FIR io_in[1]
- fir_x  out  BW_in  to FIR io_in[7:2]
- fir_y  in  BW_out  from FIR io_out
- m_valid  out  1  result valid; no backpressure
- m_data  out  BW_out  result y[n]
- busy  out  1  high in every state except IDLE
- underrun  out  1  sticky; cleared by reset or start

## Operation
- Reset values: fir_reset=1, fir_x=0, s_ready=0, m_valid=0, m_data=0, busy=0, underrun=0, all c[k]=0, state IDLE, tag pipeline cleared.
- All outputs except s_ready are registered. s_ready is high exactly when the state is STREAM.
- IDLE
  - fir_reset held at 1.
  - cfg_we writes c[cfg_addr]. Writes in any other state are ignored.
  - start moves to LOAD, and the cfg write in that same cycle is dropped.
- LOAD: N_TAPS cycles with fir_reset=0, driving fir_x = c[N_TAPS-1], c[N_TAPS-2], … c[0] in that order. This leaves FIR tap k holding c[k]. Then move to STREAM.
- STREAM, each cycle:
  - s_valid=1: fir_x <= s_data, tag 1.
  - s_valid=0: fir_x <= 0, tag 0. If at least one sample has already been accepted since start, set underrun.
  - stop=1: this cycle's handshake is still honoured, then move to DRAIN.
- DRAIN: LAT cycles driving fir_x=0 with tag 0 while pending results retire. Then go to IDLE with fir_reset<=1.
- Tag pipeline: LAT-1 stage shift register. m_valid <= tag out, and m_data <= fir_y in the same edge.
- Results are the low BW_out bits of the FIR's sum of x[n-k]*c[k]. They wrap with no saturation, and the driver passes them through unmodified.
- start, stop and cfg_we in states where they have no meaning are ignored. When start and stop arrive together in IDLE, start wins.
- Reset in any state takes effect on the next edge: everything returns to reset values and pending results are discarded, so no m_valid follows.

## Timing
- start is seen at the edge ending cycle s. LOAD covers cycles s+1..s+N_TAPS, and fir_reset falls in cycle s+1.
- STREAM begins in cycle s+N_TAPS+1, which is the first cycle with s_ready=1. The fir_x driven in that cycle is a zero bubble with tag 0.
- A sample handshaken in cycle t travels as follows:
  - appears on fir_x in cycle t+1;
  - the FIR registers it at the end of t+1;
  - the FIR sum is visible in cycle t+3;
  - m_valid/m_data are presented in cycle t+4, so latency is 4.
- Back-to-back handshakes give back-to-back m_valid with no gaps. Each s_valid gap produces exactly one m_valid=0 cycle in the output.
- stop in cycle d: the last m_valid is no later than cycle d+4. busy falls and fir_reset rises in cycle d+LAT+1.
- A new start is accepted in the first IDLE cycle. The FIR is re-reset because fir_reset is held high for at least one cycle.

## Test plan
- Identity: c0=1, c1..c4=0. Stream 5, -3 (0x3D), 31 -> m_data 0x05, 0xFD, 0x1F, with each m_valid exactly 4 cycles after its handshake.
- Delay: c2=1, others 0. Stream 7, 0, 0, 0 -> m_data 0x00, 0x00, 0x07, 0x00.
- Wrap: c0=-32, others 0, x=31 gives 0x20; all taps -32 with x=-32 continuous gives a fifth result of 5120 -> 0x00.
- Underrun: c0=1. Drop s_valid for one cycle mid-stream -> exactly one m_valid=0 gap and underrun=1. The next start clears underrun.
- Reset mid-LOAD at the 3rd load cycle -> next cycle fir_reset=1, busy=0, s_ready=0. A restart then loads the full coefficient set and the identity test passes.
- Ignored controls: cfg_we during STREAM and start during STREAM have no effect, and the stream results are unchanged.
